// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding, the blank pattern and the 3-bit digit decode table.
package display_scan_controller_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  // Segment order is a..g from left to right; a zero lights the segment.
  function automatic logic [0:6] decode_digit(input logic [2:0] value);
    logic [0:6] pattern;
    pattern = SEG_BLANK;
    unique case (value)
      3'd0: pattern = 7'b0000001;
      3'd1: pattern = 7'b1001111;
      3'd2: pattern = 7'b0010010;
      3'd3: pattern = 7'b0000110;
      3'd4: pattern = 7'b1001100;
      3'd5: pattern = 7'b0100100;
      3'd6: pattern = 7'b0100000;
      3'd7: pattern = 7'b0001111;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Write/commit bus between the switch logic and the scan controller's shadow bank.
interface display_scan_controller_if #(
  parameter int AW = 2
) ();

  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          wr_ready;
  logic          commit;
  logic          commit_pending;

  modport master (
    output wr_valid, wr_addr, wr_data, commit,
    input  wr_ready, commit_pending
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit,
    output wr_ready, commit_pending
  );

endinterface

// File: rtl/display_scan_controller_decoder.sv
// Shared combinational 3-bit to seven-segment decoder, one instance per scanner.
module displayDecoder
  import display_scan_controller_pkg::*;
(
  input  logic [2:0] value,
  output logic [0:6] seg
);

  assign seg = decode_digit(value);

endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS common-anode digits through one decoder, with blank dead-time
// between digits and a shadow bank that is published only on frame boundaries.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int AW           = $clog2(NUM_DIGITS)
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  enable,
  display_scan_controller_if.slave wr_bus,
  output logic [0:6]            seg,
  output logic [NUM_DIGITS-1:0] digit_en_n,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  scan_state_t   state;
  logic [AW-1:0] idx;
  logic [CW-1:0] counter;
  logic          commit_pending_q;
  logic [2:0]    shadow [NUM_DIGITS];
  logic [2:0]    active [NUM_DIGITS];
  logic [0:6]    seg_next;
  logic          wr_fire;

  assign wr_bus.wr_ready       = !commit_pending_q;
  assign wr_bus.commit_pending = commit_pending_q;
  assign wr_fire               = wr_bus.wr_valid && !commit_pending_q;

  displayDecoder u_decoder (
    .value (active[idx]),
    .seg   (seg_next)
  );

  // Outputs are loaded on the same edge as the state they belong to, so the
  // first SHOW cycle is already lit and any exit from SHOW blanks immediately.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state            <= OFF;
      idx              <= '0;
      counter          <= '0;
      seg              <= SEG_BLANK;
      digit_en_n       <= '1;
      frame_done       <= 1'b0;
      commit_pending_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;

      // Addresses beyond the last digit match no entry and are silently dropped.
      if (wr_fire) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (wr_bus.wr_addr == AW'(i)) begin
            shadow[i] <= wr_bus.wr_data;
          end
        end
      end

      if (wr_bus.commit && !commit_pending_q) begin
        commit_pending_q <= 1'b1;
      end

      unique case (state)
        OFF: begin
          seg        <= SEG_BLANK;
          digit_en_n <= '1;
          idx        <= '0;
          counter    <= '0;
          if (commit_pending_q) begin
            active           <= shadow;
            commit_pending_q <= 1'b0;
          end
          if (enable) begin
            state <= BLANK;
          end
        end

        BLANK: begin
          if (!enable) begin
            state      <= OFF;
            idx        <= '0;
            counter    <= '0;
            seg        <= SEG_BLANK;
            digit_en_n <= '1;
          end else if (counter == CW'(BLANK_CYCLES - 1)) begin
            state      <= SHOW;
            counter    <= '0;
            seg        <= seg_next;
            digit_en_n <= ~(NUM_DIGITS'(1) << idx);
          end else begin
            counter <= counter + CW'(1);
          end
        end

        SHOW: begin
          if (!enable) begin
            state      <= OFF;
            idx        <= '0;
            counter    <= '0;
            seg        <= SEG_BLANK;
            digit_en_n <= '1;
          end else if (counter == CW'(DWELL_CYCLES - 1)) begin
            state      <= BLANK;
            counter    <= '0;
            seg        <= SEG_BLANK;
            digit_en_n <= '1;
            // Leaving the last digit is the only place a pending commit lands
            // while scanning, so no frame ever mixes old and new values.
            if (idx == AW'(NUM_DIGITS - 1)) begin
              idx        <= '0;
              frame_done <= 1'b1;
              if (commit_pending_q) begin
                active           <= shadow;
                commit_pending_q <= 1'b0;
              end
            end else begin
              idx <= idx + AW'(1);
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end

        default: begin
          state      <= OFF;
          seg        <= SEG_BLANK;
          digit_en_n <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: a frame-position model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_display_scan_controller;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  typedef struct {
    logic [0:6]    seg;
    logic [ND-1:0] den;
    logic          fd;
    logic          pend;
    logic          rdy;
  } exp_t;

  logic          CLOCK_50;
  logic          rst_n;
  logic          enable;
  logic [0:6]    seg;
  logic [ND-1:0] digit_en_n;
  logic          frame_done;

  display_scan_controller_if #(.AW(2)) bus ();

  display_scan_controller #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_bus     (bus.slave),
    .seg        (seg),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic [0:6] seg_table [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

  // Model state: whether scanning, position within the frame, and the two banks.
  bit         m_on;
  int         m_pos;
  bit         m_pend;
  logic [2:0] m_shadow [ND];
  logic [2:0] m_active [ND];

  exp_t exp_q [$];
  int   vectors;
  int   miscompares;

  task automatic applyStimulus(input bit rst, input bit en, input bit wv,
                               input logic [1:0] wa, input logic [2:0] wd, input bit cm);
    exp_t e;
    bit   fd;
    bit   rdy;
    int   d;
    int   ph;
    rst_n        = rst;
    enable       = en;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.commit   = cm;
    @(posedge CLOCK_50);
    fd = 1'b0;
    if (!rst) begin
      m_on = 1'b0; m_pos = 0; m_pend = 1'b0;
      for (int i = 0; i < ND; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
    end else begin
      rdy = !m_pend;
      if (!m_on) begin
        if (m_pend) begin m_active = m_shadow; m_pend = 1'b0; end
        m_on  = en;
        m_pos = 0;
      end else if (!en) begin
        m_on  = 1'b0;
        m_pos = 0;
      end else if (m_pos == FRAME - 1) begin
        m_pos = 0;
        fd    = 1'b1;
        if (m_pend) begin m_active = m_shadow; m_pend = 1'b0; end
      end else begin
        m_pos++;
      end
      if (wv && rdy && int'(wa) < ND) m_shadow[wa] = wd;
      if (cm && rdy) m_pend = 1'b1;
    end
    d     = m_pos / SLOT;
    ph    = m_pos % SLOT;
    e.seg = 7'b1111111;
    e.den = '1;
    if (m_on && ph >= BL) begin
      e.den      = '1;
      e.den[d]   = 1'b0;
      e.seg      = seg_table[m_active[d]];
    end
    e.fd   = fd;
    e.pend = m_pend;
    e.rdy  = !m_pend;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (seg !== e.seg) begin
      miscompares++;
      $display("[TB] FAIL seg at %0t: got %b expected %b", $time, seg, e.seg);
    end
    if (digit_en_n !== e.den) begin
      miscompares++;
      $display("[TB] FAIL digit_en_n at %0t: got %b expected %b", $time, digit_en_n, e.den);
    end
    if (frame_done !== e.fd) begin
      miscompares++;
      $display("[TB] FAIL frame_done at %0t: got %b expected %b", $time, frame_done, e.fd);
    end
    if (bus.commit_pending !== e.pend) begin
      miscompares++;
      $display("[TB] FAIL commit_pending at %0t: got %b expected %b", $time, bus.commit_pending, e.pend);
    end
    if (bus.wr_ready !== e.rdy) begin
      miscompares++;
      $display("[TB] FAIL wr_ready at %0t: got %b expected %b", $time, bus.wr_ready, e.rdy);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic idle(input int n, input bit en);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, en, 1'b0, 2'd0, 3'd0, 1'b0);
  endtask

  initial begin
    bit         en;
    logic [2:0] vals [4];
    vectors     = 0;
    miscompares = 0;
    vals        = '{3'd3, 3'd5, 3'd7, 3'd1};

    $display("[TB] reset and first frame");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    idle(30, 1'b1);

    $display("[TB] write 3,5,7,1 then commit mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 2'(i), vals[i], 1'b0);
    for (int k = 0; k < FRAME && m_pos != 10; k++) idle(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 3'd2, 1'b0);
    idle(50, 1'b1);

    $display("[TB] write with commit in the same cycle");
    for (int k = 0; k < 2 * FRAME && m_pend; k++) idle(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 3'd6, 1'b1);
    idle(2 * FRAME + 4, 1'b1);

    $display("[TB] enable dropped during digit 2");
    for (int k = 0; k < FRAME && m_pos != 2 * SLOT + BL + 1; k++) idle(1, 1'b1);
    idle(3, 1'b0);
    idle(12, 1'b1);

    $display("[TB] reset mid-show with commit pending");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 3'd4, 1'b1);
    for (int k = 0; k < FRAME && (m_pos % SLOT) < BL + 1; k++) idle(1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    idle(30, 1'b1);

    $display("[TB] randomized traffic");
    en = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 149) == 0) en = !en;
      applyStimulus($urandom_range(0, 399) != 0, en, $urandom_range(0, 2) == 0,
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 19) == 0);
    end

    idle(1, 1'b1);
    @(negedge CLOCK_50);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes one shared 3-bit-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Holds a shadow register bank and an active register bank of 3-bit digit values. A write handshake loads the shadow bank; a commit moves shadow to active at a frame boundary.
- Sits between the board-level switch/key logic and the seven-segment pins. Drives active-low segments and active-low digit enables.

Parameters:
- NUM_DIGITS, 4: number of scanned digits, range 2..8.
- DWELL_CYCLES, 50000: clock cycles each digit is lit. Minimum 1.
- BLANK_CYCLES, 500: dead-time cycles with all digits off before each digit is lit (anti-ghosting). Minimum 1.
- AW, $clog2(NUM_DIGITS): digit address width.

Ports:
- CLOCK_50  in  1  system clock. Only clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  scan enable. Low turns the display off.
- wr_valid  in  1  write request into the shadow bank.
- wr_addr  in  AW  digit index for the write.
- wr_data  in  3  digit value 0..7.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- commit  in  1  single-cycle request to publish shadow to active.
- seg  out  [0:6]  segments a..g, active-low, registered.
- digit_en_n  out  NUM_DIGITS  per-digit enable, active-low, registered, at most one low.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- commit_pending  out  1  a commit has been requested and not yet applied.

Behaviour:
- Reset (rst_n=0 at a clock edge) sets:
  - state=OFF, idx=0, counter=0
  - seg=7'b1111111, digit_en_n=all 1
  - shadow and active banks=0
  - wr_ready=1, frame_done=0, commit_pending=0
- Reset mid-frame aborts immediately; the commit request and all values are lost.
- FSM states: OFF, BLANK, SHOW.
- OFF:
  - Outputs blanked.
  - If commit_pending, apply the copy this cycle.
  - If enable=1, go to BLANK with idx=0 and counter=0.
- BLANK:
  - All digit_en_n=1 and seg=all 1.
  - After BLANK_CYCLES cycles in BLANK, go to SHOW.
- SHOW:
  - digit_en_n[idx]=0 and seg=decode(active[idx]), both registered. The first lit cycle is the first SHOW cycle.
  - After DWELL_CYCLES cycles, go to BLANK and advance idx by one, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary: the last SHOW cycle of idx=NUM_DIGITS-1.
  - frame_done=1 on the following cycle, for exactly one cycle.
  - If commit_pending, active<=shadow on that same edge and commit_pending clears.
- Frame length = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- enable=0 in BLANK or SHOW: OFF on the next edge, outputs blanked that edge, idx reset to 0, no frame_done.
- Decode table (seg[0:6]): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
- Write handshake:
  - wr_ready = !commit_pending.
  - An accepted write updates shadow[wr_addr] on that edge.
  - wr_addr>=NUM_DIGITS is accepted and dropped.
- commit:
  - Sets commit_pending on the next edge.
  - A write accepted in the same cycle as commit is included in the published data.
  - commit while already pending is ignored.
- Active bank changes only at a frame boundary or in OFF, so a frame never shows mixed old and new data.
- Counter width is $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1). No overflow is possible.

Decomposition:
- Shared package holds:
  - FSM state encoding (OFF=2'd0, BLANK=2'd1, SHOW=2'd2)
  - SEG_BLANK=7'b1111111
  - the decode table as a function
- One natural sub-module: the existing 3-bit decoder (displayDecoder), instantiated once combinationally on active[idx], with its output registered here.
- Register banks, FSM and counter stay in this module.

Test Plan:
- All tests use NUM_DIGITS=4, DWELL=4, BLANK=2.
- Reset, then enable=1: seg=1111111 and digit_en_n=1111 for 2 cycles; then digit_en_n=1110 and seg=0000001 for 4 cycles. frame_done first pulses 24 cycles after entering BLANK.
- Write 3,5,7,1 to addr 0..3, then commit mid-frame:
  - display stays 0000001 on all digits until the frame ends.
  - next frame shows 0000110, 0100100, 0001111, 1001111.
  - commit_pending is high until frame_done.
- Write while commit_pending: wr_ready=0 and shadow unchanged. After frame_done, wr_ready=1 and the write is accepted.
- wr_valid with commit in the same cycle (addr2=6): the published frame shows digit2=0100000.
- enable dropped during SHOW of idx=2: the next edge gives digit_en_n=1111 and seg=1111111, with no frame_done. Re-enable restarts at idx=0 after 2 blank cycles.
- rst_n=0 mid-SHOW with a commit pending: next edge all outputs at reset values, commit_pending=0, active=0.
